// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_tx
//  Description : Parallel-in, serial-out transmitter. Accepts one DATA_W-bit
//                word over a valid/ready handshake and shifts it out LSB
//                first, each bit held for DIV clock cycles. A one-cycle DONE
//                state separates frames and pulses done_tick.
//                Optional build macro PISO_PARITY_EN appends an even-parity
//                bit (XOR of the captured word) held for DIV cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int DATA_W = 8,      // parallel word width, 2..32
    parameter int DIV    = 4       // clocks per serial bit, 1..65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] din,
    output logic              sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              done_tick
);

    // ------------------------------------------------------------------------
    // Counter sizing. The div counter needs at least one bit even for DIV=1,
    // where it simply stays at zero and every cycle is a terminal cycle.
    // ------------------------------------------------------------------------
    localparam int c_DIV_CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BIT_CW = $clog2(DATA_W + 1);

    localparam logic [c_DIV_CW-1:0] c_DIV_LAST = c_DIV_CW'(DIV - 1);
    localparam logic [c_BIT_CW-1:0] c_BIT_LAST = c_BIT_CW'(DATA_W - 1);
    localparam logic [c_DIV_CW-1:0] c_DIV_ONE  = c_DIV_CW'(1);
    localparam logic [c_BIT_CW-1:0] c_BIT_ONE  = c_BIT_CW'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] c_ST_PARITY = 2'd2;
`endif
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [c_BIT_CW-1:0] r_bit;
    logic [c_DIV_CW-1:0] r_div;
`ifdef PISO_PARITY_EN
    logic                r_parity;
`endif

    logic w_accept;
    logic w_div_last;
    logic w_bit_last;

    // A load is taken only when the block is ready and not being reset;
    // reset always wins over a simultaneous load request.
    assign w_accept   = load_valid & load_ready & ~reset;
    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_bit_last = (r_bit == c_BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: capture on accept, then pace the bits with the div counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bit    <= '0;
            r_div    <= '0;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_accept) begin
            // Fresh frame: both counters restart from zero, also when the
            // accept lands in the DONE cycle of the previous frame.
            r_shift  <= din;
            r_bit    <= '0;
            r_div    <= '0;
`ifdef PISO_PARITY_EN
            r_parity <= ^din;
`endif
        end else if (r_state == c_ST_SHIFT) begin
            if (w_div_last) begin
                // Bit period over: expose the next bit at shift_reg[0].
                // The bit counter ends at DATA_W after the last bit and is
                // never advanced further, so it cannot wrap.
                r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                r_bit   <= r_bit + c_BIT_ONE;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + c_DIV_ONE;
            end
`ifdef PISO_PARITY_EN
        end else if (r_state == c_ST_PARITY) begin
            // Parity bit is held for one full bit period like a data bit.
            if (w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + c_DIV_ONE;
            end
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_bit_last && w_div_last) begin
`ifdef PISO_PARITY_EN
                    w_state_nxt = c_ST_PARITY;
`else
                    w_state_nxt = c_ST_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            c_ST_PARITY: begin
                if (w_div_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                // DONE lasts exactly one cycle; a load taken here chains
                // straight into the next frame.
                if (w_accept) begin
                    w_state_nxt = c_ST_SHIFT;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from state and datapath registers only (no path from
    // load_valid or din to any output)
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        done_tick  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                load_ready = 1'b1;
            end
            c_ST_SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = r_shift[0];
            end
`ifdef PISO_PARITY_EN
            c_ST_PARITY: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = r_parity;
            end
`endif
            c_ST_DONE: begin
                load_ready = 1'b1;
                done_tick  = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_shift_tx
//  Description : Scoreboard bench for piso_shift_tx. Two instances: DIV=4 and
//                DIV=1 (8-bit words). Every accepted word pushes its expected
//                serial bits (with cycle stamps) and done_tick cycle into
//                queues; negedge monitors pop and compare. PISO_PARITY_EN
//                adds the parity bit to the expected frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    localparam int DW    = 8;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;
`ifdef PISO_PARITY_EN
    localparam int NPAR  = 1;
`else
    localparam int NPAR  = 0;
`endif
    localparam int NB    = DW + NPAR;   // serial bits per frame

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          a_load_valid, a_load_ready, a_sout, a_sout_valid, a_busy, a_done;
    logic [DW-1:0] a_din;
    logic          b_load_valid, b_load_ready, b_sout, b_sout_valid, b_busy, b_done;
    logic [DW-1:0] b_din;

    piso_shift_tx #(.DATA_W(DW), .DIV(DIV_A)) u_dut_a (
        .clk(clk), .reset(reset), .load_valid(a_load_valid), .load_ready(a_load_ready),
        .din(a_din), .sout(a_sout), .sout_valid(a_sout_valid), .busy(a_busy),
        .done_tick(a_done)
    );

    piso_shift_tx #(.DATA_W(DW), .DIV(DIV_B)) u_dut_b (
        .clk(clk), .reset(reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .din(b_din), .sout(b_sout), .sout_valid(b_sout_valid), .busy(b_busy),
        .done_tick(b_done)
    );

    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   qad[$];
    int   qbd[$];
    exp_t xa;
    exp_t xb;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Expected frame: bit k of the word held DIV cycles starting at cycle e,
    // optional parity bit last, done_tick in the cycle right after.
    task automatic push_frame(input int which, input logic [DW-1:0] d, input int e, input int div);
        for (int k = 0; k < NB; k++) begin
            logic bv;
            bv = (k < DW) ? d[k] : ^d;
            for (int j = 0; j < div; j++) begin
                exp_t x;
                x.cyc = e + k * div + j;
                x.b   = bv;
                if (which == 0) qa.push_back(x);
                else            qb.push_back(x);
            end
        end
        if (which == 0) qad.push_back(e + NB * div);
        else            qbd.push_back(e + NB * div);
    endtask

    // Present a word, wait (bounded) for load_ready, record expectations.
    // e returns the first serial cycle (the cycle after the accept edge).
    task automatic send(input int which, input logic [DW-1:0] d, input bit hold, output int e);
        int tries;
        bit rdy;
        tries = 0;
        @(negedge clk);
        if (which == 0) begin a_load_valid = 1'b1; a_din = d; end
        else            begin b_load_valid = 1'b1; b_din = d; end
        rdy = (which == 0) ? a_load_ready : b_load_ready;
        while (!rdy && tries < 300) begin
            @(negedge clk);
            tries++;
            rdy = (which == 0) ? a_load_ready : b_load_ready;
        end
        if (!rdy) begin
            chk("send_ready_timeout", 0, 1);
            e = -1;
        end else begin
            e = cyc + 1;
            push_frame(which, d, e, (which == 0) ? DIV_A : DIV_B);
        end
        @(negedge clk);
        if (!hold) begin
            if (which == 0) a_load_valid = 1'b0;
            else            b_load_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((qa.size() + qad.size() + qb.size() + qbd.size()) != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("queues_drained", qa.size() + qad.size() + qb.size() + qbd.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (a_sout_valid === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_bit", 1, 0);
            else begin
                xa = qa.pop_front();
                chk("a_bit_cycle", cyc, xa.cyc);
                chk("a_bit_value", a_sout, xa.b);
            end
        end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            void'(qa.pop_front());
            chk("a_missing_bit", 0, 1);
        end
        if (a_done === 1'b1) begin
            if (qad.size() == 0) chk("a_unexpected_done", 1, 0);
            else                 chk("a_done_cycle", cyc, qad.pop_front());
        end else if (qad.size() > 0 && qad[0] <= cyc) begin
            void'(qad.pop_front());
            chk("a_missing_done", 0, 1);
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (b_sout_valid === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_bit", 1, 0);
            else begin
                xb = qb.pop_front();
                chk("b_bit_cycle", cyc, xb.cyc);
                chk("b_bit_value", b_sout, xb.b);
            end
        end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            void'(qb.pop_front());
            chk("b_missing_bit", 0, 1);
        end
        if (b_done === 1'b1) begin
            if (qbd.size() == 0) chk("b_unexpected_done", 1, 0);
            else                 chk("b_done_cycle", cyc, qbd.pop_front());
        end else if (qbd.size() > 0 && qbd[0] <= cyc) begin
            void'(qbd.pop_front());
            chk("b_missing_done", 0, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        int e2;
        int g;
        a_load_valid = 1'b0; a_din = '0;
        b_load_valid = 1'b0; b_din = '0;

        // Reset held three cycles, then released
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_a_load_ready", a_load_ready, 1);
        chk("rst_a_sout",       a_sout,       0);
        chk("rst_a_sout_valid", a_sout_valid, 0);
        chk("rst_a_busy",       a_busy,       0);
        chk("rst_a_done",       a_done,       0);
        chk("rst_b_load_ready", b_load_ready, 1);
        chk("rst_b_sout_valid", b_sout_valid, 0);
        chk("rst_b_busy",       b_busy,       0);

        // Single 0xA5 frame: 1,0,1,0,0,1,0,1 each for 4 cycles
        send(0, 8'hA5, 1'b0, e1);
        drain();

        // Ignored load while busy: 0x00 must not disturb the 0xA5 frame
        send(0, 8'hA5, 1'b0, e1);
        repeat (5) @(negedge clk);
        a_load_valid = 1'b1;
        a_din        = 8'h00;
        chk("ign_load_ready", a_load_ready, 0);
        chk("ign_busy",       a_busy,       1);
        @(negedge clk);
        chk("ign_load_ready2", a_load_ready, 0);
        a_load_valid = 1'b0;
        drain();

        // Back-to-back with load_valid held: 0x01 then 0xFF, one gap cycle
        send(0, 8'h01, 1'b1, e1);
        send(0, 8'hFF, 1'b0, e2);
        chk("b2b_spacing", e2 - e1, NB * DIV_A + 1);
        drain();

        // Reset in cycle 10 of a frame, then a clean 0x3C frame
        send(0, 8'hA5, 1'b0, e1);
        g = 0;
        while (cyc < e1 + 9 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        reset = 1'b1;
        while (qa.size() > 0 && qa[qa.size()-1].cyc > e1 + 9) void'(qa.pop_back());
        qad.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_sout_valid", a_sout_valid, 0);
        chk("mid_rst_busy",       a_busy,       0);
        chk("mid_rst_done",       a_done,       0);
        chk("mid_rst_load_ready", a_load_ready, 1);
        send(0, 8'h3C, 1'b0, e1);
        drain();

        // DIV=1: 0x07 gives 1,1,1,0,0,0,0,0 (+ parity 1 when enabled)
        send(1, 8'h07, 1'b0, e1);
        drain();

        // DIV=1 back-to-back: 0xC3 then 0x3C, no gaps between bits
        send(1, 8'hC3, 1'b1, e1);
        send(1, 8'h3C, 1'b0, e2);
        chk("b2b_div1_spacing", e2 - e1, NB * DIV_B + 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
